// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, show-ahead receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 framing with an added o_parity_err flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  input  logic       i_rd,
  input  logic       i_clr_err,
  output logic [7:0] o_data,
  output logic       o_rx_ready,
  output logic       o_rx_DV,
  output logic       o_frame_err,
  output logic       o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;

  logic          rx_p0, rx_p1, rx_s;
  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          bit_end, half_end, stop_smp, push_req, frame_set;
  logic          vld_p1;
  logic [7:0]    data_p1;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, push, ovr_set;
  logic          frame_q, overrun_q;

  // Stage p0/p1: metastability synchronizer, idles high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx_serial;
      rx_p1 <= rx_p0;
    end
  end
  assign rx_s = rx_p1;

  assign bit_end   = (clk_cnt == BIT_END);
  assign half_end  = (clk_cnt == HALF_END);
  assign stop_smp  = (state == STOP) && bit_end;
  assign frame_set = stop_smp && !rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_bad, par_set, parity_q;
  assign par_bad  = par_q != (^shift_q);
  assign par_set  = stop_smp && par_bad;
  assign push_req = stop_smp && rx_s && !par_bad;
`else
  assign push_req = stop_smp && rx_s;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= push_req;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (half_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : BREAK;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          clk_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: assembled byte travels with vld_p1 into the FIFO
  always_ff @(posedge i_clk) begin
    if ((state == DATA) && bit_end) shift_q[bit_idx] <= rx_s;
`ifdef UART_RX_PARITY_EN
    if ((state == PARITY) && bit_end) par_q <= rx_s;
`endif
    if (push_req) data_p1 <= shift_q;
  end

  // Pop is resolved before push, so a full FIFO read in the push cycle still accepts the byte
  assign pop     = i_rd && (count != '0);
  assign push    = vld_p1 && ((count != FULL_CNT) || pop);
  assign ovr_set = vld_p1 && !push;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= data_p1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= frame_set | (frame_q & ~i_clr_err);
      overrun_q <= ovr_set | (overrun_q & ~i_clr_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_q <= 1'b0;
    else          parity_q <= par_set | (parity_q & ~i_clr_err);
  end
  assign o_parity_err = parity_q;
`endif

  assign o_rx_ready  = (count != '0);
  assign o_data      = o_rx_ready ? mem[rd_ptr] : 8'h00;
  assign o_rx_DV     = push;
  assign o_frame_err = frame_q;
  assign o_overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive path for the memory-mapped UART peripheral; mirrors the existing transmitter (8N1, same bit period).
- Samples the GPIO RX pin, reassembles bytes LSB first and buffers them in a small show-ahead FIFO.
- The register front end reads the FIFO head as RHR and uses o_rx_ready as LSR bit 0.
- Flags framing errors and overrun as sticky bits.

Parameters:
- CLKS_PER_BIT, 434: i_clk cycles per serial bit; same value as the transmitter; minimum 4.
- FIFO_DEPTH, 4: receive FIFO entries; must be a power of two, 2..16.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rx_serial  input  1  UART RX pin; asynchronous; idles high
- i_rd  input  1  one-cycle pop strobe for the FIFO head (RHR read)
- i_clr_err  input  1  one-cycle strobe; clears the sticky error flags
- o_data  output  8  FIFO head byte; 0 when FIFO is empty
- o_rx_ready  output  1  FIFO non-empty (LSR data-ready)
- o_rx_DV  output  1  one-cycle pulse when a byte is pushed into the FIFO
- o_frame_err  output  1  sticky: stop bit sampled low
- o_overrun  output  1  sticky: byte dropped because FIFO full

Behaviour:
- Reset (async, i_rst_n=0):
  - Synchronizer flops load 1; FSM goes to IDLE; counters and FIFO pointers clear.
  - All outputs 0.
  - Reset mid-frame abandons the frame; no push occurs.
- Input: 2-flop synchronizer; all sampling uses the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, clk_cnt=0.
  - START: when clk_cnt==CLKS_PER_BIT/2-1, resample.
    - rx_s==0: -> DATA, bit_idx=0, clk_cnt=0.
    - Otherwise glitch: -> IDLE, nothing recorded.
  - DATA: when clk_cnt==CLKS_PER_BIT-1, shift rx_s into bit[bit_idx] (LSB first).
    - After bit 7 -> STOP.
  - STOP: sample at CLKS_PER_BIT-1.
    - rx_s==1: push byte, -> IDLE.
    - rx_s==0: set o_frame_err, discard byte, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. A held-low line produces no further bytes or errors.
- Timing:
  - Push occurs the cycle after the stop-bit sample, about 9.5*CLKS_PER_BIT cycles after rx_s falls.
  - o_rx_DV is high for exactly that cycle.
  - A new start bit is accepted the cycle after returning to IDLE (back-to-back frames supported).
- FIFO:
  - Show-ahead: o_data = head entry, combinational from storage.
  - o_rx_ready = count!=0.
  - i_rd with empty FIFO: ignored; no pointer movement.
  - Push while full: byte dropped, o_overrun set, FIFO contents unchanged.
  - Push and i_rd in the same cycle while full: pop takes effect first, push accepted, no overrun.
  - Push and i_rd while empty: push accepted, pop ignored.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Errors:
  - Error flags stay high until i_clr_err or reset.
  - If i_clr_err and a new error occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; state PARITY sits between DATA and STOP and samples one extra bit.
  - On mismatch with even parity of the data: output o_parity_err (1 bit, sticky, cleared by i_clr_err) is set and the byte is not pushed.
  - The stop bit is still checked.
- Undefined: 8N1; no PARITY state; no o_parity_err port.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. Send 0xA5 at 16 clk/bit -> o_rx_DV pulses once ~152 cycles after the falling edge; o_data=0xA5; o_rx_ready=1. After i_rd -> o_rx_ready=0, o_data=0.
2. Low glitch of 4 cycles on an idle line -> FSM returns to IDLE; no o_rx_DV; no errors.
3. Send 0x3C with stop bit forced low, line released after 40 cycles -> o_frame_err=1, FIFO empty. Then send 0x11 -> received correctly. Pulse i_clr_err -> o_frame_err=0.
4. Send 0x01,0x02,0x03,0x04,0x05 back-to-back with no reads -> FIFO holds 01..04 and o_overrun=1. Four i_rd pops return 01,02,03,04 in order.
5. FIFO full; assert i_rd in the same cycle as the 5th byte's push -> no overrun; reads return 02,03,04,05.
6. Assert i_rst_n=0 mid DATA of 0x7E, then release and send 0x42 -> only 0x42 is received; all flags 0.
